// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART-to-SDRAM command protocol: opcodes, initiator
// FSM states and the latched command record.
package uart_cmd_pkg;

    localparam logic [7:0] CMD_WRITE = 8'h77;
    localparam logic [7:0] CMD_READ  = 8'h72;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND_OP,
        ST_SEND_ADDR,
        ST_SEND_DATA,
        ST_GAP,
        ST_WAIT_RSP
    } initiator_state_t;

    typedef struct packed {
        logic       write;
        logic [7:0] addr;
        logic [7:0] data;
    } cmd_t;

    function automatic logic [7:0] opcode_of(input logic write);
        return write ? CMD_WRITE : CMD_READ;
    endfunction

endpackage

// File: rtl/uart_cmd_initiator.sv
// Host-side command generator: serialises write/read requests into UART bytes,
// paces them with a send gap, and collects the single read response byte.
module uart_cmd_initiator
    import uart_cmd_pkg::*;
#(
    parameter int ClockFreq  = 133_000_000,
    parameter int SendDelay  = 100,
    parameter int RspTimeout = 2_000_000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_cmd_valid,
    output logic       o_cmd_ready,
    input  logic       i_cmd_write,
    input  logic [7:0] i_cmd_addr,
    input  logic [7:0] i_cmd_data,
    output logic       o_wr_done,
    output logic       o_rsp_valid,
    output logic [7:0] o_rsp_data,
    output logic       o_timeout,
    output logic       o_rx_drop,
    output logic [7:0] o_tx_data,
    output logic       o_tx_req,
    input  logic       i_tx_rdy,
    input  logic [7:0] i_rx_data,
    input  logic       i_rx_rdy,
    output logic       o_rx_req
);

    localparam int GapW = $clog2(SendDelay);
    localparam int ToW  = $clog2(RspTimeout);
    localparam logic [GapW-1:0] GapLoad = GapW'(SendDelay - 1);
    localparam logic [ToW-1:0]  ToLast  = ToW'(RspTimeout - 1);

    if (SendDelay < 2 || RspTimeout < 2 || ClockFreq < 1) begin : g_param_check
        $error("uart_cmd_initiator: SendDelay and RspTimeout must be >= 2");
    end

    initiator_state_t state_q, state_d;
    initiator_state_t sent_q, sent_d;   // which byte the current GAP follows
    cmd_t             cmd_q, cmd_d;
    logic [GapW-1:0]  gap_q, gap_d;
    logic [ToW-1:0]   to_q, to_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_req_q, tx_req_d;
    logic             rx_req_q, rx_req_d;
    logic [7:0]       rsp_data_q, rsp_data_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             timeout_q, timeout_d;
    logic             rx_drop_q, rx_drop_d;
    logic             wr_done_q, wr_done_d;
    logic             rx_take;

    always_comb begin
        state_d     = state_q;
        sent_d      = sent_q;
        cmd_d       = cmd_q;
        gap_d       = gap_q;
        to_d        = to_q;
        rsp_data_d  = rsp_data_q;
        tx_data_d   = 8'h00;
        tx_req_d    = 1'b0;
        rsp_valid_d = 1'b0;
        timeout_d   = 1'b0;
        wr_done_d   = 1'b0;

        // Ack pulse blocks the next capture, so at most one byte every 2 cycles
        rx_take   = i_rx_rdy && !rx_req_q;
        rx_req_d  = rx_take;
        rx_drop_d = rx_take && (state_q != ST_WAIT_RSP);

        case (state_q)
            ST_IDLE: begin
                if (i_cmd_valid) begin
                    cmd_d   = '{write: i_cmd_write, addr: i_cmd_addr, data: i_cmd_data};
                    state_d = ST_SEND_OP;
                end
            end
            ST_SEND_OP: begin
                if (i_tx_rdy) begin
                    tx_req_d  = 1'b1;
                    tx_data_d = opcode_of(cmd_q.write);
                    gap_d     = GapLoad;
                    sent_d    = ST_SEND_OP;
                    state_d   = ST_GAP;
                end
            end
            ST_SEND_ADDR: begin
                if (i_tx_rdy) begin
                    tx_req_d  = 1'b1;
                    tx_data_d = cmd_q.addr;
                    if (cmd_q.write) begin
                        gap_d   = GapLoad;
                        sent_d  = ST_SEND_ADDR;
                        state_d = ST_GAP;
                    end else begin
                        to_d    = '0;
                        state_d = ST_WAIT_RSP;
                    end
                end
            end
            ST_SEND_DATA: begin
                if (i_tx_rdy) begin
                    tx_req_d  = 1'b1;
                    tx_data_d = cmd_q.data;
                    gap_d     = GapLoad;
                    sent_d    = ST_SEND_DATA;
                    state_d   = ST_GAP;
                end
            end
            ST_GAP: begin
                if (sent_q == ST_SEND_DATA) begin
                    // Done pulses once the gap has fully elapsed, then IDLE
                    if (gap_q != '0) begin
                        gap_d = gap_q - GapW'(1);
                    end else if (!wr_done_q) begin
                        wr_done_d = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (gap_q <= GapW'(1)) begin
                    gap_d   = '0;
                    state_d = (sent_q == ST_SEND_OP) ? ST_SEND_ADDR : ST_SEND_DATA;
                end else begin
                    gap_d = gap_q - GapW'(1);
                end
            end
            ST_WAIT_RSP: begin
                if (rx_take) begin
                    rsp_data_d  = i_rx_data;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_IDLE;
                end else if (to_q == ToLast) begin
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    to_d = to_q + ToW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            sent_q      <= ST_IDLE;
            cmd_q       <= '0;
            gap_q       <= '0;
            to_q        <= '0;
            tx_data_q   <= 8'h00;
            tx_req_q    <= 1'b0;
            rx_req_q    <= 1'b0;
            rsp_data_q  <= 8'h00;
            rsp_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            rx_drop_q   <= 1'b0;
            wr_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sent_q      <= sent_d;
            cmd_q       <= cmd_d;
            gap_q       <= gap_d;
            to_q        <= to_d;
            tx_data_q   <= tx_data_d;
            tx_req_q    <= tx_req_d;
            rx_req_q    <= rx_req_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
            timeout_q   <= timeout_d;
            rx_drop_q   <= rx_drop_d;
            wr_done_q   <= wr_done_d;
        end
    end

    assign o_cmd_ready = (state_q == ST_IDLE);
    assign o_wr_done   = wr_done_q;
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_data  = rsp_data_q;
    assign o_timeout   = timeout_q;
    assign o_rx_drop   = rx_drop_q;
    assign o_tx_data   = tx_data_q;
    assign o_tx_req    = tx_req_q;
    assign o_rx_req    = rx_req_q;

endmodule

// File: tb/tb_uart_cmd_initiator.sv
// Directed bench for uart_cmd_initiator with SendDelay = 4 and RspTimeout = 50.
module tb_uart_cmd_initiator;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_cmd_valid = 1'b0;
    logic       o_cmd_ready;
    logic       i_cmd_write = 1'b0;
    logic [7:0] i_cmd_addr = 8'h00;
    logic [7:0] i_cmd_data = 8'h00;
    logic       o_wr_done;
    logic       o_rsp_valid;
    logic [7:0] o_rsp_data;
    logic       o_timeout;
    logic       o_rx_drop;
    logic [7:0] o_tx_data;
    logic       o_tx_req;
    logic       i_tx_rdy = 1'b1;
    logic [7:0] i_rx_data = 8'h00;
    logic       i_rx_rdy = 1'b0;
    logic       o_rx_req;

    uart_cmd_initiator #(
        .ClockFreq (133_000_000),
        .SendDelay (4),
        .RspTimeout(50)
    ) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_cmd_valid(i_cmd_valid),
        .o_cmd_ready(o_cmd_ready),
        .i_cmd_write(i_cmd_write),
        .i_cmd_addr (i_cmd_addr),
        .i_cmd_data (i_cmd_data),
        .o_wr_done  (o_wr_done),
        .o_rsp_valid(o_rsp_valid),
        .o_rsp_data (o_rsp_data),
        .o_timeout  (o_timeout),
        .o_rx_drop  (o_rx_drop),
        .o_tx_data  (o_tx_data),
        .o_tx_req   (o_tx_req),
        .i_tx_rdy   (i_tx_rdy),
        .i_rx_data  (i_rx_data),
        .i_rx_rdy   (i_rx_rdy),
        .o_rx_req   (o_rx_req)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic       write;
        logic [7:0] addr;
        logic [7:0] data;
        int         stall;     // cycles of i_tx_rdy=0 starting at the opcode cycle
        int         rsp_dly;   // rx byte offered this many cycles after addr tx (-1: none)
        logic [7:0] rsp_byte;
        int         n_tx;
        logic [7:0] b0, b1, b2;
        int         off1;      // addr tx cycle minus opcode tx cycle
        int         off2;      // data tx cycle minus opcode tx cycle
        int         done_off;  // wr_done cycle minus data tx cycle
        int         exp_rsp;
        int         rsp_off;   // rsp_valid cycle minus addr tx cycle
        int         exp_to;
        int         to_off;    // timeout cycle minus addr tx cycle
    } vec_t;

    vec_t vecs[7];
    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_tx_req"}, int'(o_tx_req), 0);
        chk({tag, "_tx_data"}, int'(o_tx_data), 0);
        chk({tag, "_wr_done"}, int'(o_wr_done), 0);
        chk({tag, "_rsp_valid"}, int'(o_rsp_valid), 0);
        chk({tag, "_rsp_data"}, int'(o_rsp_data), 0);
        chk({tag, "_timeout"}, int'(o_timeout), 0);
        chk({tag, "_rx_req"}, int'(o_rx_req), 0);
        chk({tag, "_rx_drop"}, int'(o_rx_drop), 0);
        chk({tag, "_ready"}, int'(o_cmd_ready), 1);
    endtask

    // Entered and left just after a falling edge, with the DUT in IDLE.
    task automatic run_vec(input vec_t v, input string tag);
        int tx_n, done_n, done_c, rsp_n, rsp_c, to_n, to_c, rxreq_n, drop_n, bad_idle;
        int txc[3];
        logic [7:0] txb[3];
        logic [7:0] rsp_d;
        tx_n = 0; done_n = 0; done_c = -1; rsp_n = 0; rsp_c = -1;
        to_n = 0; to_c = -1; rxreq_n = 0; drop_n = 0; bad_idle = 0; rsp_d = 8'h00;
        for (int i = 0; i < 3; i++) begin
            txc[i] = -1;
            txb[i] = 8'h00;
        end
        chk({tag, "_ready_before"}, int'(o_cmd_ready), 1);
        i_tx_rdy    = 1'b1;
        i_cmd_valid = 1'b1;
        i_cmd_write = v.write;
        i_cmd_addr  = v.addr;
        i_cmd_data  = v.data;
        @(negedge i_clk);
        i_cmd_valid = 1'b0;
        for (int c = 0; c < 90; c++) begin
            if (o_tx_req) begin
                if (tx_n < 3) begin
                    txb[tx_n] = o_tx_data;
                    txc[tx_n] = c;
                end
                tx_n++;
            end else if (o_tx_data != 8'h00) begin
                bad_idle++;
            end
            if (o_wr_done) begin done_n++; done_c = c; end
            if (o_rsp_valid) begin rsp_n++; rsp_c = c; rsp_d = o_rsp_data; end
            if (o_timeout) begin to_n++; to_c = c; end
            if (o_rx_drop) drop_n++;
            if (o_rx_req) begin
                rxreq_n++;
                i_rx_rdy = 1'b0;
            end
            i_tx_rdy = !(tx_n > 0 && c < txc[0] + v.stall);
            if (v.rsp_dly >= 0 && tx_n >= 2 && c == txc[1] + v.rsp_dly) begin
                i_rx_rdy  = 1'b1;
                i_rx_data = v.rsp_byte;
            end
            @(negedge i_clk);
        end
        i_tx_rdy = 1'b1;
        chk({tag, "_n_tx"}, tx_n, v.n_tx);
        chk({tag, "_op_latency"}, txc[0], 1);
        chk({tag, "_byte0"}, int'(txb[0]), int'(v.b0));
        chk({tag, "_byte1"}, int'(txb[1]), int'(v.b1));
        chk({tag, "_addr_spacing"}, txc[1] - txc[0], v.off1);
        if (v.write) begin
            chk({tag, "_byte2"}, int'(txb[2]), int'(v.b2));
            chk({tag, "_data_spacing"}, txc[2] - txc[0], v.off2);
            chk({tag, "_done_delay"}, done_c - txc[2], v.done_off);
        end
        chk({tag, "_wr_done_count"}, done_n, int'(v.write));
        chk({tag, "_rsp_count"}, rsp_n, v.exp_rsp);
        if (v.exp_rsp != 0) begin
            chk({tag, "_rsp_delay"}, rsp_c - txc[1], v.rsp_off);
            chk({tag, "_rsp_data"}, int'(rsp_d), int'(v.rsp_byte));
            chk({tag, "_rsp_hold"}, int'(o_rsp_data), int'(v.rsp_byte));
        end
        chk({tag, "_timeout_count"}, to_n, v.exp_to);
        if (v.exp_to != 0) chk({tag, "_timeout_delay"}, to_c - txc[1], v.to_off);
        chk({tag, "_rx_req_count"}, rxreq_n, (v.rsp_dly >= 0) ? 1 : 0);
        chk({tag, "_rx_drop_count"}, drop_n, 0);
        chk({tag, "_tx_data_idle"}, bad_idle, 0);
        chk({tag, "_ready_after"}, int'(o_cmd_ready), 1);
    endtask

    initial begin
        int seen;
        int tx_cnt;
        int done_cnt;
        //        wr    addr   data   stl dly  rbyte  n  b0     b1     b2     o1  o2  dn rsp roff to toff
        vecs[0] = '{1'b1, 8'h12, 8'hA5, 0, -1, 8'h00, 3, 8'h77, 8'h12, 8'hA5, 4,  8, 4, 0, 0,  0, 0};
        vecs[1] = '{1'b0, 8'h3C, 8'h00, 0, 10, 8'h5A, 2, 8'h72, 8'h3C, 8'h00, 4,  0, 0, 1, 11, 0, 0};
        vecs[2] = '{1'b0, 8'h44, 8'h00, 0, -1, 8'h00, 2, 8'h72, 8'h44, 8'h00, 4,  0, 0, 0, 0,  1, 50};
        vecs[3] = '{1'b0, 8'h45, 8'h00, 0, 49, 8'hC3, 2, 8'h72, 8'h45, 8'h00, 4,  0, 0, 1, 50, 0, 0};
        vecs[4] = '{1'b1, 8'h01, 8'h02, 23, -1, 8'h00, 3, 8'h77, 8'h01, 8'h02, 24, 28, 4, 0, 0, 0, 0};
        vecs[5] = '{1'b1, 8'hFF, 8'h00, 2, -1, 8'h00, 3, 8'h77, 8'hFF, 8'h00, 4,  8, 4, 0, 0,  0, 0};
        vecs[6] = '{1'b0, 8'h00, 8'h00, 0, 0,  8'h81, 2, 8'h72, 8'h00, 8'h00, 4,  0, 0, 1, 1,  0, 0};

        repeat (3) @(negedge i_clk);
        chk_quiet("reset");
        i_rst_n = 1'b1;
        @(negedge i_clk);

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i], $sformatf("v%0d", i));
        end

        // Unsolicited byte in IDLE is acknowledged and dropped
        i_rx_rdy  = 1'b1;
        i_rx_data = 8'hFF;
        @(negedge i_clk);
        chk("unsol_rx_req", int'(o_rx_req), 1);
        chk("unsol_rx_drop", int'(o_rx_drop), 1);
        chk("unsol_rsp_valid", int'(o_rsp_valid), 0);
        chk("unsol_rsp_hold", int'(o_rsp_data), 8'h81);
        i_rx_rdy = 1'b0;
        @(negedge i_clk);
        chk("unsol_rx_req_once", int'(o_rx_req), 0);
        chk("unsol_rx_drop_once", int'(o_rx_drop), 0);
        run_vec(vecs[1], "after_unsol");

        // Reset during the write's gap after the addr byte
        i_cmd_valid = 1'b1;
        i_cmd_write = 1'b1;
        i_cmd_addr  = 8'h34;
        i_cmd_data  = 8'h55;
        @(negedge i_clk);
        i_cmd_valid = 1'b0;
        seen = 0;
        for (int k = 0; k < 30; k++) begin
            if (o_tx_req) seen++;
            if (seen == 2) break;
            @(negedge i_clk);
        end
        chk("rst_addr_seen", seen, 2);
        @(negedge i_clk);
        i_rst_n = 1'b0;
        @(negedge i_clk);
        chk_quiet("midrst");
        i_rst_n = 1'b1;
        tx_cnt = 0;
        done_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge i_clk);
            if (o_tx_req) tx_cnt++;
            if (o_wr_done) done_cnt++;
        end
        chk("midrst_no_tx", tx_cnt, 0);
        chk("midrst_no_done", done_cnt, 0);
        run_vec(vecs[0], "after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
